// File: rtl/mem_access_stage_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : shrv32_mem_pkg                                             |
// | Description : Shared definitions for the shrv32 memory-access stage:     |
// |               RV32I load/store funct3 encodings, the MA state encoding   |
// |               and a funct3 legality helper.                              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package shrv32_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } ma_state_t;

  // Unsigned sizes only exist for loads; stores accept B/H/W.
  function automatic logic f3_legal(input logic load, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = load;
      default:          f3_legal = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : mem_access_stage_if                                        |
// | Description : Simple req/ready data bus between the MA stage (master)    |
// |               and memory (slave).                                        |
// | Ports       : mem_req, mem_we, mem_addr[31:0], mem_wstrb[3:0],           |
// |               mem_wdata[31:0] (master->slave); mem_ready,                |
// |               mem_rdata[31:0] (slave->master).                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface mem_access_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_stage_lane.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_lane_align                                             |
// | Description : Combinational byte-lane logic for RV32I loads/stores.      |
// | Ports       : funct3[2:0], addr_lo[1:0]  access size/sign and offset     |
// |               wdata[31:0]    store data (rs2)                            |
// |               rdata[31:0]    raw bus read word                           |
// |               wstrb[3:0]     byte enables for the access                 |
// |               wdata_rep[31:0] store data replicated across lanes         |
// |               rdata_ext[31:0] selected lane, sign/zero extended          |
// |               misaligned     halfword/word offset violation              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mem_lane_align
  import shrv32_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte     = rdata[7:0];
    w_half     = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    wstrb      = 4'b1111;
    wdata_rep  = wdata;
    rdata_ext  = rdata;
    misaligned = 1'b0;

    case (addr_lo)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase

    // funct3[1:0] carries the size for both signed and unsigned variants.
    case (funct3[1:0])
      2'b00: begin
        wstrb     = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        wstrb      = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep  = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
      end
      default: begin
        wstrb      = 4'b1111;
        wdata_rep  = wdata;
        misaligned = |addr_lo;
      end
    endcase

    case (funct3)
      F3_B:    rdata_ext = {{24{w_byte[7]}}, w_byte};
      F3_H:    rdata_ext = {{16{w_half[15]}}, w_half};
      F3_BU:   rdata_ext = {24'd0, w_byte};
      F3_HU:   rdata_ext = {16'd0, w_half};
      default: rdata_ext = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mem_access_stage                                           |
// | Description : shrv32 memory-access stage. One RV32I load/store per       |
// |               ma_start strobe over a req/ready bus, with illegal/        |
// |               misaligned detection and an optional ready timeout.        |
// | Ports       : CLK, RST_N (async, active-low)                             |
// |               ma_start, is_load, is_store, funct3, addr, wdata (from EX) |
// |               mem_wait, done, rdata, err (to core / clock generator)     |
// |               bus : mem_access_stage_if.master (data bus)                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mem_access_stage
  import shrv32_mem_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      ma_start,
  input  logic                      is_load,
  input  logic                      is_store,
  input  logic [2:0]                funct3,
  input  logic [31:0]               addr,
  input  logic [31:0]               wdata,
  output logic                      mem_wait,
  output logic                      done,
  output logic [31:0]               rdata,
  output logic                      err,
  mem_access_stage_if.master        bus
);

  localparam logic [CNT_W-1:0] c_to_last = CNT_W'(TIMEOUT - 1);

  ma_state_t        r_state, w_next;
  logic             r_err, w_err_nxt;
  logic [31:0]      r_addr, r_wdata, r_rdata;
  logic [2:0]       r_f3;
  logic             r_load, r_store;
  logic [CNT_W-1:0] r_cnt;

  logic             w_idle, w_in_req, w_st_req, w_expire;
  logic [2:0]       w_f3;
  logic [1:0]       w_lo;
  logic [3:0]       w_wstrb;
  logic [31:0]      w_wdata_rep, w_load_ext;
  logic             w_misaligned;

  assign w_idle   = (r_state == IDLE);
  assign w_in_req = (r_state == REQ);
  assign w_st_req = w_in_req & r_store;
  assign w_expire = (TIMEOUT != 0) && (r_cnt == c_to_last);

  // In IDLE the aligner looks at the live EX inputs so the start decision
  // can see misalignment; afterwards it works from the latched access.
  assign w_f3 = w_idle ? funct3    : r_f3;
  assign w_lo = w_idle ? addr[1:0] : r_addr[1:0];

  mem_lane_align u_align (
    .funct3     (w_f3),
    .addr_lo    (w_lo),
    .wdata      (r_wdata),
    .rdata      (bus.mem_rdata),
    .wstrb      (w_wstrb),
    .wdata_rep  (w_wdata_rep),
    .rdata_ext  (w_load_ext),
    .misaligned (w_misaligned)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_err_nxt = r_err;
    case (r_state)
      IDLE: begin
        if (ma_start) begin
          if (!(is_load || is_store)) begin
            w_next    = DONE;
            w_err_nxt = 1'b0;
          end else if (!f3_legal(is_load, funct3) || w_misaligned) begin
            w_next    = DONE;
            w_err_nxt = 1'b1;
          end else begin
            w_next    = REQ;
            w_err_nxt = 1'b0;
          end
        end
      end
      REQ: begin
        // Ready on the expiry cycle still completes normally.
        if (bus.mem_ready) begin
          w_next    = DONE;
          w_err_nxt = 1'b0;
        end else if (w_expire) begin
          w_next    = DONE;
          w_err_nxt = 1'b1;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_f3    <= '0;
      r_load  <= 1'b0;
      r_store <= 1'b0;
      r_cnt   <= '0;
      r_rdata <= '0;
    end else begin
      if (w_idle && ma_start) begin
        r_addr  <= addr;
        r_wdata <= wdata;
        r_f3    <= funct3;
        r_load  <= is_load;
        r_store <= is_store;
      end
      if (w_in_req && !bus.mem_ready) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
      if (w_in_req && bus.mem_ready && r_load) begin
        r_rdata <= w_load_ext;
      end
    end
  end

  assign mem_wait = !w_idle;
  assign done     = (r_state == DONE);
  assign err      = done & r_err;
  assign rdata    = r_rdata;

  // Bus outputs are forced to zero outside REQ so reset or timeout drops
  // the request in the same cycle the state leaves REQ.
  assign bus.mem_req   = w_in_req;
  assign bus.mem_we    = w_st_req;
  assign bus.mem_addr  = w_in_req ? {r_addr[31:2], 2'b00} : 32'd0;
  assign bus.mem_wstrb = w_st_req ? w_wstrb : 4'd0;
  assign bus.mem_wdata = w_st_req ? w_wdata_rep : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mem_access_stage                                        |
// | Description : Scoreboard bench for mem_access_stage (TIMEOUT=4).         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mem_access_stage;
  import shrv32_mem_pkg::*;

  logic        CLK, RST_N;
  logic        ma_start, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        mem_wait, done, err;
  logic [31:0] rdata;

  mem_access_stage_if bus();

  mem_access_stage #(.TIMEOUT(4), .CNT_W(8)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .ma_start (ma_start),
    .is_load  (is_load),
    .is_store (is_store),
    .funct3   (funct3),
    .addr     (addr),
    .wdata    (wdata),
    .mem_wait (mem_wait),
    .done     (done),
    .rdata    (rdata),
    .err      (err),
    .bus      (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          req;
    int          lat;
    int          t0;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  int          req_seen = 0;
  logic [31:0] model_rd = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: bus phase compared every request cycle, completion on done.
  always @(negedge CLK) begin
    if (!RST_N) begin
      sb.delete();
      req_seen = 0;
    end else begin
      if (bus.mem_req) begin
        if (sb.size() == 0) begin
          chk("unexpected_req", 32'd1, 32'd0);
        end else begin
          chk("mem_addr",  bus.mem_addr,           sb[0].addr);
          chk("mem_we",    {31'd0, bus.mem_we},    {31'd0, sb[0].we});
          chk("mem_wstrb", {28'd0, bus.mem_wstrb}, {28'd0, sb[0].strb});
          chk("mem_wdata", bus.mem_wdata,          sb[0].wdata);
          chk("wait_req",  {31'd0, mem_wait},      32'd1);
          req_seen++;
        end
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rdata",     rdata,              e.rdata);
          chk("err",       {31'd0, err},       {31'd0, e.err});
          chk("req_count", 32'(req_seen),      32'(e.req));
          chk("latency",   32'(cyc - e.t0),    32'(e.lat));
          chk("wait_done", {31'd0, mem_wait},  32'd1);
          req_seen = 0;
        end
      end
    end
  end

  task automatic drain();
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge CLK);
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  // waits: REQ cycles before ready (-1 = never); nreq: expected REQ cycles.
  task automatic run(input logic ld, input logic st, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rw,
                     input int waits, input int nreq, input logic e_err,
                     input logic upd, input logic [31:0] newrd,
                     input logic [3:0] strb, input logic [31:0] bwd, input logic poke);
    exp_t e;
    @(negedge CLK);
    if (upd) model_rd = newrd;
    e.rdata = model_rd; e.err = e_err; e.req = nreq; e.lat = nreq + 1; e.t0 = cyc;
    e.addr = {a[31:2], 2'b00}; e.we = st; e.strb = strb; e.wdata = bwd;
    sb.push_back(e);
    ma_start = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; wdata = wd;
    @(negedge CLK);
    ma_start = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    for (int i = 0; i < nreq; i++) begin
      bus.mem_ready = (i == waits);
      bus.mem_rdata = (i == waits) ? rw : 32'h5A5A_0F0F;
      if (poke && i == 1) begin
        ma_start = 1'b1; is_load = 1'b1; funct3 = F3_W; addr = 32'h0000_0F00;
      end
      @(negedge CLK);
      ma_start = 1'b0; is_load = 1'b0; funct3 = 3'd0; addr = 32'd0;
    end
    bus.mem_ready = 1'b0;
    drain();
  endtask

  initial begin
    RST_N = 1'b0; ma_start = 1'b0; is_load = 1'b0; is_store = 1'b0;
    funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    bus.mem_ready = 1'b0; bus.mem_rdata = 32'd0;
    #1;
    chk("rst_mem_req",  {31'd0, bus.mem_req}, 32'd0);
    chk("rst_mem_wait", {31'd0, mem_wait},    32'd0);
    chk("rst_done",     {31'd0, done},        32'd0);
    chk("rst_err",      {31'd0, err},         32'd0);
    chk("rst_rdata",    rdata,                32'd0);
    chk("rst_mem_addr", bus.mem_addr,         32'd0);
    chk("rst_wstrb",    {28'd0, bus.mem_wstrb}, 32'd0);
    #22 RST_N = 1'b1;

    //  ld   st    f3     addr          wdata         rword        w  n  err upd newrd          strb     bus wdata     poke
    run(1'b1,1'b0,F3_W, 32'h0000_0100,32'd0,        32'hDEADBEEF, 0, 1,1'b0,1'b1,32'hDEADBEEF,4'b0000,32'd0,        1'b0);
    run(1'b1,1'b0,F3_B, 32'h0000_0203,32'd0,        32'h80FF1234, 0, 1,1'b0,1'b1,32'hFFFFFF80,4'b0000,32'd0,        1'b0);
    run(1'b1,1'b0,F3_BU,32'h0000_0203,32'd0,        32'h80FF1234, 0, 1,1'b0,1'b1,32'h00000080,4'b0000,32'd0,        1'b0);
    run(1'b1,1'b0,F3_HU,32'h0000_0202,32'd0,        32'h80FF1234, 0, 1,1'b0,1'b1,32'h000080FF,4'b0000,32'd0,        1'b0);
    run(1'b1,1'b0,F3_H, 32'h0000_0202,32'd0,        32'h80FF1234, 1, 2,1'b0,1'b1,32'hFFFF80FF,4'b0000,32'd0,        1'b0);
    // SH with 3 wait cycles; ready lands on the expiry cycle and must win.
    run(1'b0,1'b1,F3_H, 32'h0000_000A,32'h1234ABCD, 32'd0,        3, 4,1'b0,1'b0,32'd0,       4'b1100,32'hABCDABCD, 1'b1);
    run(1'b0,1'b1,F3_B, 32'h0000_0101,32'h000000A5, 32'd0,        1, 2,1'b0,1'b0,32'd0,       4'b0010,32'hA5A5A5A5, 1'b0);
    run(1'b0,1'b1,F3_W, 32'h0000_0010,32'hCAFEF00D, 32'd0,        0, 1,1'b0,1'b0,32'd0,       4'b1111,32'hCAFEF00D, 1'b0);
    // Error and no-op paths: no bus activity, done one cycle after start.
    run(1'b0,1'b1,F3_W, 32'h0000_0102,32'h11111111, 32'd0,       -1, 0,1'b1,1'b0,32'd0,       4'b0000,32'd0,        1'b0);
    run(1'b1,1'b0,3'b011,32'h0000_0100,32'd0,       32'd0,       -1, 0,1'b1,1'b0,32'd0,       4'b0000,32'd0,        1'b0);
    run(1'b0,1'b1,F3_BU,32'h0000_0100,32'd0,        32'd0,       -1, 0,1'b1,1'b0,32'd0,       4'b0000,32'd0,        1'b0);
    run(1'b1,1'b0,F3_H, 32'h0000_0201,32'd0,        32'd0,       -1, 0,1'b1,1'b0,32'd0,       4'b0000,32'd0,        1'b0);
    run(1'b0,1'b0,F3_W, 32'h0000_0100,32'd0,        32'd0,       -1, 0,1'b0,1'b0,32'd0,       4'b0000,32'd0,        1'b0);
    // Timeout: four request cycles without ready, rdata unchanged.
    run(1'b1,1'b0,F3_W, 32'h0000_0300,32'd0,        32'd0,       -1, 4,1'b1,1'b0,32'd0,       4'b0000,32'd0,        1'b0);
    run(1'b1,1'b0,F3_W, 32'h0000_0300,32'd0,        32'h11223344, 3, 4,1'b0,1'b1,32'h11223344,4'b0000,32'd0,        1'b0);

    // Reset in the middle of a REQ wait.
    @(negedge CLK);
    sb.push_back('{rdata: model_rd, err: 1'b0, req: 9, lat: 9, t0: cyc,
                   addr: 32'h0000_0400, we: 1'b0, strb: 4'b0000, wdata: 32'd0});
    ma_start = 1'b1; is_load = 1'b1; funct3 = F3_W; addr = 32'h0000_0400;
    @(negedge CLK);
    ma_start = 1'b0; is_load = 1'b0; funct3 = 3'd0; addr = 32'd0;
    @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk("midrst_mem_req",  {31'd0, bus.mem_req}, 32'd0);
    chk("midrst_mem_wait", {31'd0, mem_wait},    32'd0);
    chk("midrst_done",     {31'd0, done},        32'd0);
    chk("midrst_rdata",    rdata,                32'd0);
    model_rd = 32'd0;
    @(negedge CLK);
    @(negedge CLK);
    #2 RST_N = 1'b1;
    run(1'b1,1'b0,F3_B, 32'h0000_0001,32'd0,        32'h00007F00, 0, 1,1'b0,1'b1,32'h0000007F,4'b0000,32'd0,        1'b0);

    repeat (3) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
